// File: rtl/fifo_rd_pkt_unpack.sv
// fifo_rd_pkt_unpack
// Pops words from an upstream FIFO and re-emits them as framed packets.
// A header word carries the payload length in bits [7:0]. Headers longer
// than MAX_LEN cause the whole packet to be silently discarded and counted.
// A single output register stage sits between the FIFO and the downstream
// valid/ready interface; popping is allowed whenever that register is free,
// so the block sustains one word per clock across packet boundaries.
module fifo_rd_pkt_unpack #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_fifo_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  input  logic        i_ready,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_sop;
  logic        r_eop;
  logic [15:0] r_drop_cnt;

  logic        w_out_free;
  logic        w_pop;
  logic [7:0]  w_len;
  logic        w_last;
  logic        w_drop_sat;

  // The output register can take a new word when it is empty or its word is
  // being accepted this cycle. While dropping, nothing is written to it, so
  // its occupancy does not matter. rst_n gates the pop so the FIFO is never
  // drained while the block is held in reset.
  assign w_out_free   = !r_valid || i_ready;
  assign w_pop        = rst_n && !i_fifo_empty && ((r_state == ST_DROP) || w_out_free);
  assign w_len        = i_fifo_data[7:0];
  assign w_last       = (r_cnt <= 8'd1);
  assign w_drop_sat   = (r_drop_cnt == 16'hFFFF);

  assign o_fifo_rd_en = w_pop;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_sop        = r_sop;
  assign o_eop        = r_eop;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_busy       = (r_state != ST_HDR);

  // Packet framing FSM together with the output register and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HDR;
      r_cnt      <= 8'd0;
      r_data     <= 32'd0;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (w_pop) begin
      unique case (r_state)
        ST_HDR: begin
          if (w_len == 8'd0) begin
            r_data  <= i_fifo_data;
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b1;
          end else if (w_len <= LP_MAX_LEN) begin
            r_data  <= i_fifo_data;
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_cnt   <= w_len;
            r_state <= ST_PAYLOAD;
          end else begin
            r_valid <= 1'b0;
            r_cnt   <= w_len;
            r_state <= ST_DROP;
            if (!w_drop_sat) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          r_data  <= i_fifo_data;
          r_valid <= 1'b1;
          r_sop   <= 1'b0;
          r_eop   <= w_last;
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
          if (w_last) begin
            r_state <= ST_HDR;
          end
        end
        ST_DROP: begin
          if (r_valid && i_ready) begin
            r_valid <= 1'b0;
          end
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
          if (w_last) begin
            r_state <= ST_HDR;
          end
        end
        default: begin
          r_state <= ST_HDR;
          r_cnt   <= 8'd0;
        end
      endcase
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
